euler_result_printer: RTL and testbench
=======================================

Name: euler_result_printer

Overview:
- Downstream consumer of the Euler-sum core (the even-Fibonacci accumulator).
- Waits for the core's IsEnd, then latches the 32-bit sum and converts it to decimal with an iterative double-dabble.
- Streams the result as ASCII digits, most significant first with no leading zeros, followed by a terminator byte, over a valid/ready byte interface toward a UART TX or a log sink.
- Runs once per reset.

Parameters:
- Width, 32: bit width of the Sum input.
- Digits, 10: BCD digit count; must satisfy 10^Digits > 2^Width.
- Term, 8'h0A: terminator byte sent after the last digit.

Ports:
- CLK  input  1  sole clock, rising edge.
- Init  input  1  reset, asynchronous, active-low.
- IsEnd  input  1  core finished; level, stays high once set.
- Sum  input  Width  core result; sampled only on the trigger edge.
- Data  output  8  ASCII byte.
- Valid  output  1  Data holds a byte to transfer.
- Ready  input  1  sink accepts the byte; a transfer occurs on a CLK edge with Valid&Ready.
- Busy  output  1  high from trigger until Done.
- Done  output  1  high after the terminator transfers; sticky until reset.

Behaviour:
- Reset (Init=0, async): state IDLE; Data=0, Valid=0, Busy=0, Done=0; BCD register, shift register and counters cleared. Reset in any state aborts immediately; after Init rises the block waits in IDLE again.
- IDLE: on an edge with IsEnd=1, latch Sum into the shift register, clear BCD, set bit counter 0, Busy=1, go CONV. If IsEnd=0, stay.
- CONV: each edge performs one double-dabble step.
  - Add 3 to every BCD nibble >=5.
  - Shift {BCD, shift} left by 1.
  - After exactly Width edges (32), go SKIP with digit index = Digits-1.
- SKIP: one edge per leading zero.
  - If the digit at the index is 0 and index>0, decrement the index.
  - Otherwise load Data=8'h30+digit, Valid=1, go EMIT.
  - Sum=0 therefore emits a single "0".
- EMIT:
  - Data and Valid held stable while Ready=0.
  - On Valid&Ready with index>0: decrement index, Data=next digit, Valid stays 1 (back-to-back bytes, no bubble).
  - On Valid&Ready with index=0: Data=Term, go TERM.
- TERM: on Valid&Ready: Valid=0, Data=0, Busy=0, Done=1, go DONE.
- DONE: terminal state. IsEnd (still high) is ignored. Only reset re-arms the block.
- Sum is don't-care outside the trigger edge; later changes must not affect output.
- Ready with Valid=0 has no effect. Ready may be high permanently.
- Latency with Ready=1 throughout, counted in edges from trigger to first Valid=1 sample: 1 (latch) + 32 (CONV) + leading-zero count + 1.
- Total bytes sent = significant digits + 1.
- Width arithmetic:
  - BCD register is 4*Digits bits.
  - Nibble correction is 4-bit; no carry between nibbles, since the add-3 step never overflows a nibble.
  - Digit-to-ASCII is 8-bit: 8'h30 | {4'b0, nibble}.

Decomposition:
- Shared package euler_pkg holds:
  - State enum {IDLE, CONV, SKIP, EMIT, TERM, DONE}.
  - ASCII_ZERO=8'h30 and ASCII_LF=8'h0A.
  - A function that returns the digit count for a given width.
- One sub-module, bin2bcd_iter:
  - Inputs: start, bin.
  - Outputs: bcd[4*Digits-1:0], done.
  - Implements the iterative double-dabble engine, reused by other result printers.
- The top level holds the FSM, the digit index and the byte handshake.

Test Plan:
- Sum=4613732, IsEnd raised, Ready=1: bytes 34 36 31 33 37 33 32 0A in order; first Valid at edge 1+32+3+1=37 after trigger; Done=1 after the 0A transfer, Busy=0.
- Sum=0: bytes 30 0A only; Sum=4294967295: bytes 34 32 39 34 39 36 37 32 39 35 0A, with no SKIP cycles.
- Backpressure: Ready held 0 for 5 edges during the 3rd byte of the 4613732 stream: Data=31 and Valid=1 stable throughout, no byte lost or duplicated.
- Sum changed to 123 one edge after the trigger, and IsEnd kept high after Done: output still "4613732\n"; no second stream.
- Init pulsed low mid-EMIT: Valid, Busy and Done drop immediately (asynchronously). After release with IsEnd=1 and Sum=7: stream "7\n" is sent.
- IsEnd=0 for 100 edges: Valid=0, Busy=0, Done=0 throughout.

Source files
------------

// File: rtl/euler_pkg.sv
// euler_pkg: shared state encoding, ASCII constants and BCD sizing helper for result printers.
package euler_pkg;
  typedef enum logic [2:0] {IDLE, CONV, SKIP, EMIT, TERM, DONE} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  function automatic int digits_for(input int width);
    longint unsigned lim;
    longint unsigned p;
    int d;
    lim = (64'd1 << width) - 64'd1;
    p = 64'd10;
    d = 1;
    for (int i = 0; i < 19; i++)
      if (p <= lim) begin
        p = p * 64'd10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_iter.sv
// bin2bcd_iter: iterative double-dabble, one bit per clock after start.
module bin2bcd_iter #(
  parameter int Width = 32,
  parameter int Digits = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Width-1:0]      bin,
  output logic [4*Digits-1:0]   bcd,
  output logic                  done
);
  localparam int CW = $clog2(Width + 1);
  logic [4*Digits-1:0] bcd_q, bcd_d, adj;
  logic [Width-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  // done marks the edge that performs the final step; bcd is complete right after it
  assign done = busy_q && (cnt_q == CW'(Width - 1));
  assign bcd = bcd_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < Digits; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bcd_d = start ? '0 : busy_q ? {adj[4*Digits-2:0], shift_q[Width-1]} : bcd_q;
    shift_d = start ? bin : busy_q ? shift_q << 1 : shift_q;
    cnt_d = start ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
    busy_d = start || (busy_q && !done);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcd_q <= '0;
      shift_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
endmodule

// File: rtl/euler_result_printer.sv
// euler_result_printer: on IsEnd, converts Sum to decimal and streams ASCII digits plus a terminator.
module euler_result_printer
  import euler_pkg::*;
#(
  parameter int Width = 32,
  parameter int Digits = digits_for(Width),
  parameter logic [7:0] Term = ASCII_LF
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             IsEnd,
  input  logic [Width-1:0] Sum,
  output logic [7:0]       Data,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Done
);
  localparam int IW = $clog2(Digits);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_m1;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic start, conv_done;
  logic [4*Digits-1:0] bcd;
  logic [3:0] cur_digit, nxt_digit;
  bin2bcd_iter #(.Width(Width), .Digits(Digits)) u_conv (
    .clk(CLK), .rst_n(Init), .start(start), .bin(Sum), .bcd(bcd), .done(conv_done)
  );
  assign idx_m1 = idx_q - 1'b1;
  assign cur_digit = bcd[{idx_q, 2'b00} +: 4];
  assign nxt_digit = bcd[{idx_m1, 2'b00} +: 4];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = done_q;
    start = 1'b0;
    case (state_q)
      IDLE: if (IsEnd) begin
        start = 1'b1;
        busy_d = 1'b1;
        state_d = CONV;
      end
      CONV: if (conv_done) begin
        idx_d = IW'(Digits - 1);
        state_d = SKIP;
      end
      SKIP: if (cur_digit == 4'd0 && idx_q != '0) idx_d = idx_m1;
      else begin
        data_d = ASCII_ZERO | {4'b0, cur_digit};
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (Ready) begin
        idx_d = (idx_q != '0) ? idx_m1 : idx_q;
        data_d = (idx_q != '0) ? (ASCII_ZERO | {4'b0, nxt_digit}) : Term;
        state_d = (idx_q != '0) ? EMIT : TERM;
      end
      TERM: if (Ready) begin
        valid_d = 1'b0;
        data_d = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge CLK or negedge Init)
    if (!Init) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign Data = data_q;
  assign Valid = valid_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule

// File: tb/tb_euler_result_printer.sv
// tb_euler_result_printer: randomized and directed streams checked against a decimal-string model.
module tb_euler_result_printer;
  logic CLK = 1'b0;
  logic Init = 1'b0;
  logic IsEnd = 1'b0;
  logic Ready = 1'b0;
  logic [31:0] Sum = '0;
  logic [7:0] Data;
  logic Valid, Busy, Done;
  int nvec = 0;
  int nerr = 0;

  euler_result_printer dut (
    .CLK(CLK), .Init(Init), .IsEnd(IsEnd), .Sum(Sum), .Data(Data),
    .Valid(Valid), .Ready(Ready), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset;
    Init = 1'b0;
    IsEnd = 1'b0;
    Ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Init = 1'b1;
  endtask

  function automatic string hexq(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  task automatic run_stream(input logic [31:0] s, input bit rnd, input int bp, input bit chk_lat);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    string str;
    int lat, stall;
    bit seen, fin, ok;
    str = $sformatf("%0d", s);
    for (int i = 0; i < str.len(); i++) exp_q.push_back(8'(str[i]));
    exp_q.push_back(8'h0A);
    lat = 34 + 10 - str.len();
    seen = 1'b0;
    fin = 1'b0;
    stall = 0;
    Sum = s;
    IsEnd = 1'b1;
    Ready = 1'b1;
    for (int e = 1; e <= 600 && !fin; e++) begin
      @(posedge CLK);
      #1;
      if (e == 1) Sum = $urandom;
      if (Valid && !seen) begin
        seen = 1'b1;
        if (chk_lat) begin
          nvec++;
          if (e != lat) begin
            nerr++;
            $display("FAIL latency sum=%0d: first Valid after edge %0d, expected %0d", s, e, lat);
          end
        end
      end
      if (bp >= 0 && got_q.size() == bp && Valid && stall < 5) begin
        nvec++;
        if (Data !== exp_q[bp]) begin
          nerr++;
          $display("FAIL stall sum=%0d: Data=%h during backpressure, expected %h", s, Data, exp_q[bp]);
        end
        Ready = 1'b0;
        stall++;
      end else Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Valid && Ready) got_q.push_back(Data);
      fin = Done;
    end
    nvec++;
    if (Done !== 1'b1) begin
      nerr++;
      $display("FAIL timeout sum=%0d: Done=%b after cycle budget, expected 1", s, Done);
    end
    nvec++;
    if (Busy !== 1'b0 || Valid !== 1'b0 || Data !== 8'h00) begin
      nerr++;
      $display("FAIL idle_after_done sum=%0d: Busy/Valid/Data=%b/%b/%h, expected 0/0/00", s, Busy, Valid, Data);
    end
    ok = (got_q.size() == exp_q.size());
    for (int i = 0; ok && i < exp_q.size(); i++) ok = (got_q[i] === exp_q[i]);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL bytes sum=%0d: got %s expected %s", s, hexq(got_q), hexq(exp_q));
    end
    Ready = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge CLK);
      #1;
      nvec++;
      if (Valid !== 1'b0 || Done !== 1'b1) begin
        nerr++;
        $display("FAIL rearm sum=%0d: Valid/Done=%b/%b after Done, expected 0/1", s, Valid, Done);
      end
    end
  endtask

  task automatic test_reset;
    Init = 1'b0;
    IsEnd = 1'b1;
    Sum = 32'd99;
    repeat (3) @(posedge CLK);
    #1;
    nvec++;
    if (Data !== 8'h00 || Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      nerr++;
      $display("FAIL reset: Data/Valid/Busy/Done=%h/%b/%b/%b, expected 00/0/0/0", Data, Valid, Busy, Done);
    end
    IsEnd = 1'b0;
  endtask

  task automatic test_idle;
    do_reset;
    IsEnd = 1'b0;
    Ready = 1'b1;
    for (int e = 0; e < 100; e++) begin
      Sum = $urandom;
      @(posedge CLK);
      #1;
      nvec++;
      if (Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
        nerr++;
        $display("FAIL idle edge %0d: Valid/Busy/Done=%b/%b/%b, expected 0/0/0", e, Valid, Busy, Done);
      end
    end
  endtask

  task automatic test_known;
    do_reset;
    run_stream(32'd4613732, 1'b0, -1, 1'b1);
    do_reset;
    run_stream(32'd0, 1'b0, -1, 1'b1);
    do_reset;
    run_stream(32'hFFFF_FFFF, 1'b0, -1, 1'b1);
  endtask

  task automatic test_backpressure;
    do_reset;
    run_stream(32'd4613732, 1'b0, 2, 1'b1);
  endtask

  task automatic test_abort;
    do_reset;
    Sum = 32'd4613732;
    IsEnd = 1'b1;
    Ready = 1'b1;
    for (int e = 0; e < 60 && !Valid; e++) begin
      @(posedge CLK);
      #1;
    end
    nvec++;
    if (Valid !== 1'b1) begin
      nerr++;
      $display("FAIL abort_setup: Valid=%b before abort, expected 1", Valid);
    end
    @(posedge CLK);
    #1 Init = 1'b0;
    #1;
    nvec++;
    if (Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Data !== 8'h00) begin
      nerr++;
      $display("FAIL abort: Valid/Busy/Done/Data=%b/%b/%b/%h, expected 0/0/0/00", Valid, Busy, Done, Data);
    end
    @(posedge CLK);
    #1 Init = 1'b1;
    run_stream(32'd7, 1'b0, -1, 1'b1);
  endtask

  task automatic test_random;
    logic [31:0] s;
    for (int i = 0; i < 10; i++) begin
      s = (i % 2 == 1) ? $urandom : 32'($urandom_range(0, 99999));
      do_reset;
      run_stream(s, i >= 2, -1, i < 2);
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_known;
    test_backpressure;
    test_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
